// File: rtl/gray_tracker.sv
// -----------------------------------------------------------------------------
// gray_tracker
//
// Purpose:
//   Decodes a reflected-binary Gray code sampled from a gray counter and
//   tracks the counter's motion between accepted samples. Each sample is
//   classified as a hold, a single up-step, a single down-step, or an
//   illegal jump. Wrap-around steps raise sticky Overflow/Underflow flags.
//
// Optional feature:
//   GRAY_STEP_CHECK_EN -- when defined, illegal jumps set the sticky
//   Step_err flag. When undefined, Step_err is tied to 0 and illegal jumps
//   simply resynchronise Binary to the new value.
//
// Parameters:
//   WIDTH      Gray code width in bits (2..8)
//
// Ports:
//   Clk        in   clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   En         in   sample strobe; Gray_in is captured when high
//   Clr        in   synchronous clear of flags and tracking state (wins over En)
//   Gray_in    in   [WIDTH-1:0] Gray code input
//   Binary     out  [WIDTH-1:0] registered binary value of the last sample
//   Valid      out  one-cycle pulse after each accepted sample
//   Dir        out  direction of the last legal nonzero step (1=up, 0=down)
//   Overflow   out  sticky: up-step from all-ones to zero
//   Underflow  out  sticky: down-step from zero to all-ones
//   Step_err   out  sticky: illegal (non-adjacent) step
// -----------------------------------------------------------------------------
module gray_tracker #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             En,
  input  logic             Clr,
  input  logic [WIDTH-1:0] Gray_in,
  output logic [WIDTH-1:0] Binary,
  output logic             Valid,
  output logic             Dir,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Step_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_t;

  // MSB passes through; each lower bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_bin, w_bin_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_unf, w_unf_nxt;
  logic [WIDTH-1:0] w_new_bin;
  logic [WIDTH-1:0] w_delta;
`ifdef GRAY_STEP_CHECK_EN
  logic             r_err, w_err_nxt;
`endif

  assign w_new_bin = gray2bin(Gray_in);
  // Modular distance from the held value; wraps naturally at WIDTH bits.
  assign w_delta   = w_new_bin - r_bin;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= EMPTY;
      r_bin   <= '0;
      r_valid <= 1'b0;
      r_dir   <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
`ifdef GRAY_STEP_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_valid <= w_valid_nxt;
      r_dir   <= w_dir_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
`ifdef GRAY_STEP_CHECK_EN
      r_err   <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_valid_nxt = 1'b0;
    w_dir_nxt   = r_dir;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
`ifdef GRAY_STEP_CHECK_EN
    w_err_nxt   = r_err;
`endif
    if (Clr) begin
      // Clear drops any coincident sample; Binary is deliberately kept.
      w_state_nxt = EMPTY;
      w_dir_nxt   = 1'b0;
      w_ovf_nxt   = 1'b0;
      w_unf_nxt   = 1'b0;
`ifdef GRAY_STEP_CHECK_EN
      w_err_nxt   = 1'b0;
`endif
    end else if (En) begin
      w_valid_nxt = 1'b1;
      if (r_state == EMPTY) begin
        // First sample after reset/clear is a reference only.
        w_bin_nxt   = w_new_bin;
        w_state_nxt = TRACK;
      end else if (w_delta == ZERO_VAL) begin
        w_bin_nxt = r_bin;
      end else if (w_delta == ONE_VAL) begin
        w_bin_nxt = w_new_bin;
        w_dir_nxt = 1'b1;
        if (r_bin == MAX_VAL) w_ovf_nxt = 1'b1;
      end else if (w_delta == MAX_VAL) begin
        w_bin_nxt = w_new_bin;
        w_dir_nxt = 1'b0;
        if (r_bin == ZERO_VAL) w_unf_nxt = 1'b1;
      end else begin
        // Non-adjacent jump: resync to the new value, direction untouched.
        w_bin_nxt = w_new_bin;
`ifdef GRAY_STEP_CHECK_EN
        w_err_nxt = 1'b1;
`endif
      end
    end
  end

  assign Binary    = r_bin;
  assign Valid     = r_valid;
  assign Dir       = r_dir;
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;
`ifdef GRAY_STEP_CHECK_EN
  assign Step_err  = r_err;
`else
  assign Step_err  = 1'b0;
`endif

endmodule

// File: tb/tb_gray_tracker.sv
// -----------------------------------------------------------------------------
// tb_gray_tracker
//
// Self-checking bench for gray_tracker at WIDTH=3. Directed scenarios cover
// reset, the full count sequence with wrap, underflow, non-adjacent jumps,
// clear priority, asynchronous reset mid-stream and holds; a randomized run
// compares every cycle against an integer reference model of the tracker.
// Expectations follow GRAY_STEP_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_gray_tracker;

  localparam int W    = 3;
  localparam int MASK = (1 << W) - 1;
`ifdef GRAY_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b1;
  logic         En = 1'b0;
  logic         Clr = 1'b0;
  logic [W-1:0] Gray_in = '0;
  logic [W-1:0] Binary;
  logic         Valid, Dir, Overflow, Underflow, Step_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_ref;
  int m_bin;
  bit m_valid, m_dir, m_ovf, m_unf, m_err;

  gray_tracker #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .En(En), .Clr(Clr), .Gray_in(Gray_in),
    .Binary(Binary), .Valid(Valid), .Dir(Dir), .Overflow(Overflow),
    .Underflow(Underflow), .Step_err(Step_err)
  );

  always #5 Clk = ~Clk;

  function automatic int g2b(input int g);
    int b;
    b = g;
    for (int s = g >> 1; s != 0; s = s >> 1) b = b ^ s;
    return b;
  endfunction

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] dut_vec();
    return {Binary, Valid, Dir, Overflow, Underflow, Step_err};
  endfunction

  function automatic logic [7:0] model_vec();
    logic [W-1:0] b;
    b = m_bin[W-1:0];
    return {b, m_valid, m_dir, m_ovf, m_unf, m_err};
  endfunction

  task automatic model_reset();
    m_ref = 0; m_bin = 0; m_valid = 0; m_dir = 0; m_ovf = 0; m_unf = 0; m_err = 0;
  endtask

  task automatic model_apply(input bit en, input bit clr, input int g);
    int nb, d;
    if (clr) begin
      m_ref = 0; m_valid = 0; m_dir = 0; m_ovf = 0; m_unf = 0; m_err = 0;
    end else if (en) begin
      m_valid = 1;
      nb = g2b(g);
      if (!m_ref) begin
        m_bin = nb;
        m_ref = 1;
      end else begin
        d = (nb - m_bin) & MASK;
        if (d == 1) begin
          if (m_bin == MASK) m_ovf = 1;
          m_dir = 1; m_bin = nb;
        end else if (d == MASK) begin
          if (m_bin == 0) m_unf = 1;
          m_dir = 0; m_bin = nb;
        end else if (d != 0) begin
          m_bin = nb;
          if (CHK) m_err = 1;
        end
      end
    end else begin
      m_valid = 0;
    end
  endtask

  // Apply one cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic drive(input bit en, input bit clr, input int g);
    logic [31:0] gv;
    gv = g;
    @(negedge Clk);
    En = en; Clr = clr; Gray_in = gv[W-1:0];
    @(posedge Clk);
    model_apply(en, clr, g);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0; En = 1'b0; Clr = 1'b0;
    model_reset();
    @(posedge Clk);
    #1;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 8'h00) begin
      errors++;
      $display("FAIL reset_async got %b exp %b", dut_vec(), 8'h00);
    end
    do_reset();
    drive(0, 0, 0);
    checks++;
    if (dut_vec() !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle got %b exp %b", dut_vec(), 8'h00);
    end
  endtask

  task automatic test_count_sequence();
    int seq [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(1, 0, seq[k]);
      checks++;
      if (Binary !== 3'(k % 8) || Valid !== 1'b1) begin
        errors++;
        $display("FAIL count_step%0d got bin=%0d vld=%b exp bin=%0d vld=1", k, Binary, Valid, k % 8);
      end
    end
    checks++;
    if ({Dir, Overflow, Underflow, Step_err} !== 4'b1100) begin
      errors++;
      $display("FAIL count_flags got %b exp 1100", {Dir, Overflow, Underflow, Step_err});
    end
    drive(0, 0, 0);
    checks++;
    if (Valid !== 1'b0 || Binary !== 3'd0 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL count_idle got %b exp %b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_underflow();
    do_reset();
    drive(1, 0, 3'b000);
    drive(1, 0, 3'b100);
    checks++;
    if ({Binary, Dir, Underflow, Overflow} !== {3'd7, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL underflow got bin=%0d dir=%b unf=%b ovf=%b exp bin=7 dir=0 unf=1 ovf=0",
               Binary, Dir, Underflow, Overflow);
    end
  endtask

  task automatic test_nonadjacent();
    do_reset();
    drive(1, 0, 3'b000);
    drive(1, 0, 3'b010);
    checks++;
    if (Binary !== 3'd3 || Step_err !== CHK || Dir !== 1'b0) begin
      errors++;
      $display("FAIL nonadjacent got bin=%0d err=%b dir=%b exp bin=3 err=%b dir=0",
               Binary, Step_err, Dir, CHK);
    end
  endtask

  task automatic test_clr_priority();
    int seq [10] = '{0, 1, 3, 2, 6, 7, 5, 4, 0, 2};
    do_reset();
    foreach (seq[k]) drive(1, 0, seq[k]);
    checks++;
    if (Overflow !== 1'b1 || Step_err !== CHK || Binary !== 3'd3) begin
      errors++;
      $display("FAIL clr_setup got ovf=%b err=%b bin=%0d exp ovf=1 err=%b bin=3",
               Overflow, Step_err, Binary, CHK);
    end
    drive(1, 1, 3'b001);
    checks++;
    if (dut_vec() !== {3'd3, 5'b00000}) begin
      errors++;
      $display("FAIL clr_wins got %b exp %b", dut_vec(), {3'd3, 5'b00000});
    end
    drive(1, 0, 3'b111);
    checks++;
    if (dut_vec() !== {3'd5, 5'b10000}) begin
      errors++;
      $display("FAIL clr_reference got %b exp %b", dut_vec(), {3'd5, 5'b10000});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 0, 3'b000);
    drive(1, 0, 3'b001);
    drive(1, 0, 3'b011);
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got %b exp %b", dut_vec(), 8'h00);
    end
    Reset_n = 1'b1;
    drive(1, 0, 3'b110);
    checks++;
    if (dut_vec() !== {3'd4, 5'b10000}) begin
      errors++;
      $display("FAIL async_reset_ref got %b exp %b", dut_vec(), {3'd4, 5'b10000});
    end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1, 0, 3'b000);
    drive(1, 0, 3'b001);
    drive(1, 0, 3'b011);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 3'b011);
      checks++;
      if (dut_vec() !== {3'd2, 5'b11000}) begin
        errors++;
        $display("FAIL hold%0d got %b exp %b", k, dut_vec(), {3'd2, 5'b11000});
      end
    end
  endtask

  task automatic test_random();
    int r, tgt;
    bit en, clr;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      en  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 29) == 0);
      r   = $urandom_range(0, 9);
      if (r < 4)      tgt = (m_bin + 1) & MASK;
      else if (r < 7) tgt = (m_bin - 1) & MASK;
      else if (r < 8) tgt = m_bin;
      else            tgt = $urandom_range(0, MASK);
      drive(en, clr, b2g(tgt));
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random%0d got %b exp %b", n, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count_sequence();
    test_underflow();
    test_nonadjacent();
    test_clr_priority();
    test_async_reset();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
